// File: rtl/ac_bmc_vr_pwrgd_responder.sv
// Responder for the four BMC AUX regulators: answers enables with delayed power-good,
// supports per-rail fault injection and flags out-of-order enable/disable sequencing.
module ac_bmc_vr_pwrgd_responder #(
    parameter int T_ON_CYC  = 2000,
    parameter int T_OFF_CYC = 1000,
    parameter int CNT_W     = 12
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iFM_PCH_P1V8_AUX_EN,
    input  logic       iFM_P2V5_BMC_AUX_EN,
    input  logic       iFM_P1V2_BMC_AUX_EN,
    input  logic       iFM_P1V0_BMC_AUX_EN,
    input  logic [3:0] iFAULT_INJ,
    output logic       oPWRGD_P1V8_BMC_AUX,
    output logic       oPWRGD_P2V5_BMC_AUX,
    output logic       oPWRGD_P1V2_BMC_AUX,
    output logic       oPWRGD_P1V0_BMC_AUX,
    output logic [3:0] oRAIL_FAULT,
    output logic [3:0] oSEQ_ERR_UP,
    output logic [3:0] oSEQ_ERR_DN
);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN,
        ST_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] T_ON_LAST  = CNT_W'(T_ON_CYC - 1);
    localparam logic [CNT_W-1:0] T_OFF_LAST = CNT_W'(T_OFF_CYC - 1);

    state_t           state_q [4];
    state_t           state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       pwrgd_q, pwrgd_d;
    logic [3:0]       fault_q, fault_d;
    logic [3:0]       en_q, en_d;
    logic [3:0]       seq_up_q, seq_up_d;
    logic [3:0]       seq_dn_q, seq_dn_d;
    logic [3:0]       en, en_rise, en_fall;

    // Bit order is power-up order.
    assign en = {iFM_P1V0_BMC_AUX_EN, iFM_P1V2_BMC_AUX_EN,
                 iFM_P2V5_BMC_AUX_EN, iFM_PCH_P1V8_AUX_EN};
    assign en_rise = en & ~en_q;
    assign en_fall = ~en & en_q;

    always_comb begin
        en_d    = en;
        pwrgd_d = pwrgd_q;
        fault_d = fault_q;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    cnt_d[i]   = '0;
                    pwrgd_d[i] = 1'b0;
                    fault_d[i] = 1'b0;
                    if (en[i]) state_d[i] = ST_RAMP_UP;
                end
                ST_RAMP_UP: begin
                    if (!en[i]) begin
                        state_d[i] = ST_OFF;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == T_ON_LAST) begin
                        state_d[i] = ST_ON;
                        pwrgd_d[i] = 1'b1;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    // Fault wins over an enable drop in the same cycle.
                    if (iFAULT_INJ[i]) begin
                        state_d[i] = ST_FAULT;
                        pwrgd_d[i] = 1'b0;
                        fault_d[i] = 1'b1;
                    end else if (!en[i]) begin
                        state_d[i] = ST_RAMP_DOWN;
                        cnt_d[i]   = '0;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (en[i]) begin
                        state_d[i] = ST_ON;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == T_OFF_LAST) begin
                        state_d[i] = ST_OFF;
                        pwrgd_d[i] = 1'b0;
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_FAULT: begin
                    cnt_d[i] = '0;
                    if (!en[i]) begin
                        state_d[i] = ST_OFF;
                        fault_d[i] = 1'b0;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    cnt_d[i]   = '0;
                    pwrgd_d[i] = 1'b0;
                    fault_d[i] = 1'b0;
                end
            endcase
        end
        // Order checks use this cycle's registered power-good of the neighbour rail.
        seq_up_d = seq_up_q | {en_rise[3:1] & ~pwrgd_q[2:0], 1'b0};
        seq_dn_d = seq_dn_q | {1'b0, en_fall[2:0] & pwrgd_q[3:1]};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            pwrgd_q  <= '0;
            fault_q  <= '0;
            en_q     <= '0;
            seq_up_q <= '0;
            seq_dn_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pwrgd_q  <= pwrgd_d;
            fault_q  <= fault_d;
            en_q     <= en_d;
            seq_up_q <= seq_up_d;
            seq_dn_q <= seq_dn_d;
        end
    end

    assign oPWRGD_P1V8_BMC_AUX = pwrgd_q[0];
    assign oPWRGD_P2V5_BMC_AUX = pwrgd_q[1];
    assign oPWRGD_P1V2_BMC_AUX = pwrgd_q[2];
    assign oPWRGD_P1V0_BMC_AUX = pwrgd_q[3];
    assign oRAIL_FAULT         = fault_q;
    assign oSEQ_ERR_UP         = seq_up_q;
    assign oSEQ_ERR_DN         = seq_dn_q;

endmodule

// File: tb/tb_ac_bmc_vr_pwrgd_responder.sv
// Directed bench for ac_bmc_vr_pwrgd_responder with a cycle-tagged expected queue
// and an independent negedge monitor.
module tb_ac_bmc_vr_pwrgd_responder;

    localparam int W = 48;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en  = 4'b0000;
    logic [3:0] fi  = 4'b0000;
    logic       pg0, pg1, pg2, pg3;
    logic [3:0] rail_fault, seq_up, seq_dn;
    logic [31:0] cyc = 32'd0;

    logic [W-1:0] exp_q[$];
    string        nm_q[$];
    int           checks = 0;
    int           errors = 0;

    ac_bmc_vr_pwrgd_responder #(
        .T_ON_CYC (4),
        .T_OFF_CYC(2),
        .CNT_W    (12)
    ) dut (
        .iClk               (clk),
        .iRst               (rst),
        .iFM_PCH_P1V8_AUX_EN(en[0]),
        .iFM_P2V5_BMC_AUX_EN(en[1]),
        .iFM_P1V2_BMC_AUX_EN(en[2]),
        .iFM_P1V0_BMC_AUX_EN(en[3]),
        .iFAULT_INJ         (fi),
        .oPWRGD_P1V8_BMC_AUX(pg0),
        .oPWRGD_P2V5_BMC_AUX(pg1),
        .oPWRGD_P1V2_BMC_AUX(pg2),
        .oPWRGD_P1V0_BMC_AUX(pg3),
        .oRAIL_FAULT        (rail_fault),
        .oSEQ_ERR_UP        (seq_up),
        .oSEQ_ERR_DN        (seq_dn)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // expected outputs visible at the negedge after posedge number cyc+dc
    task automatic chk(input int dc, input logic [3:0] pg, input logic [3:0] f,
                       input logic [3:0] up, input logic [3:0] dn, input string nm);
        exp_q.push_back({cyc + 32'(dc), pg, f, up, dn});
        nm_q.push_back(nm);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] ent;
        logic [15:0]  obs;
        string        nm;
        obs = {pg3, pg2, pg1, pg0, rail_fault, seq_up, seq_dn};
        while (exp_q.size() > 0 && exp_q[0][47:16] <= cyc) begin
            ent = exp_q.pop_front();
            nm  = nm_q.pop_front();
            checks++;
            if (ent[47:16] != cyc) begin
                errors++;
                $display("FAIL %s stale tag=%0d cyc=%0d", nm, ent[47:16], cyc);
            end else if (obs !== ent[15:0]) begin
                errors++;
                $display("FAIL %s cyc=%0d pg_flt_up_dn got=%b_%b_%b_%b want=%b_%b_%b_%b",
                         nm, cyc, obs[15:12], obs[11:8], obs[7:4], obs[3:0],
                         ent[15:12], ent[11:8], ent[7:4], ent[3:0]);
            end
        end
    end

    initial begin
        // reset state
        tick(2);
        chk(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, "reset");
        tick(1);
        rst = 1'b0;

        // in-order power-up
        en = 4'b0001; chk(4, 4'b0000, 0, 0, 0, "up0_early"); chk(5, 4'b0001, 0, 0, 0, "up0"); tick(5);
        en = 4'b0011; chk(4, 4'b0001, 0, 0, 0, "up1_early"); chk(5, 4'b0011, 0, 0, 0, "up1"); tick(5);
        en = 4'b0111; chk(4, 4'b0011, 0, 0, 0, "up2_early"); chk(5, 4'b0111, 0, 0, 0, "up2"); tick(5);
        en = 4'b1111; chk(4, 4'b0111, 0, 0, 0, "up3_early"); chk(5, 4'b1111, 0, 0, 0, "up3"); tick(5);

        // in-order power-down
        en = 4'b0111; chk(2, 4'b1111, 0, 0, 0, "dn3_early"); chk(3, 4'b0111, 0, 0, 0, "dn3"); tick(3);
        en = 4'b0011; chk(2, 4'b0111, 0, 0, 0, "dn2_early"); chk(3, 4'b0011, 0, 0, 0, "dn2"); tick(3);
        en = 4'b0001; chk(2, 4'b0011, 0, 0, 0, "dn1_early"); chk(3, 4'b0001, 0, 0, 0, "dn1"); tick(3);
        en = 4'b0000; chk(2, 4'b0001, 0, 0, 0, "dn0_early"); chk(3, 4'b0000, 0, 0, 0, "dn0"); tick(3);

        // out-of-order enable of rail 2
        en = 4'b0001; chk(5, 4'b0001, 0, 0, 0, "seq_r0_on"); tick(5);
        en = 4'b0101; chk(1, 4'b0001, 0, 4'b0100, 0, "seq_up2_set");
        chk(5, 4'b0101, 0, 4'b0100, 0, "seq_r2_on"); tick(5);
        en = 4'b0000; chk(3, 4'b0000, 0, 4'b0100, 0, "seq_sticky"); tick(3);

        // fault on rail 1
        en = 4'b0001; chk(5, 4'b0001, 0, 4'b0100, 0, "flt_r0_on"); tick(5);
        en = 4'b0011; chk(5, 4'b0011, 0, 4'b0100, 0, "flt_r1_on"); tick(5);
        fi = 4'b0010; chk(1, 4'b0001, 4'b0010, 4'b0100, 0, "flt_enter"); tick(1);
        fi = 4'b0000; chk(10, 4'b0001, 4'b0010, 4'b0100, 0, "flt_hold"); tick(10);
        en = 4'b0001; chk(1, 4'b0001, 4'b0000, 4'b0100, 0, "flt_exit"); tick(1);
        en = 4'b0011; chk(4, 4'b0001, 0, 4'b0100, 0, "flt_reon_early");
        chk(5, 4'b0011, 0, 4'b0100, 0, "flt_reon"); tick(5);

        // short enable pulse on rail 3 (out of order too)
        en = 4'b1011; chk(1, 4'b0011, 0, 4'b1100, 0, "pulse_up3_err"); tick(2);
        en = 4'b0011; chk(4, 4'b0011, 0, 4'b1100, 0, "pulse_no_pg"); tick(4);

        // one-cycle enable glitch on ON rail 1
        en = 4'b0001; chk(1, 4'b0011, 0, 4'b1100, 0, "glitch_a"); tick(1);
        en = 4'b0011; chk(1, 4'b0011, 0, 4'b1100, 0, "glitch_b");
        chk(3, 4'b0011, 0, 4'b1100, 0, "glitch_c"); tick(3);

        // fault and enable drop on rail 0 together, all rails ON
        en = 4'b0111; chk(5, 4'b0111, 0, 4'b1100, 0, "all_r2_on"); tick(5);
        en = 4'b1111; chk(5, 4'b1111, 0, 4'b1100, 0, "all_r3_on"); tick(5);
        fi = 4'b0001; en = 4'b1110;
        chk(1, 4'b1110, 4'b0001, 4'b1100, 4'b0001, "flt_drop_same"); tick(1);
        fi = 4'b0000;
        chk(1, 4'b1110, 4'b0000, 4'b1100, 4'b0001, "flt_drop_exit"); tick(1);

        // reset mid-ramp (rail 0) and in ON (rails 1..3)
        en = 4'b1111; tick(2);
        rst = 1'b1; chk(1, 4'b0000, 0, 0, 0, "rst_clear"); tick(1);
        rst = 1'b0;
        chk(1, 4'b0000, 0, 4'b1110, 0, "rst_rel_seq");
        chk(4, 4'b0000, 0, 4'b1110, 0, "rst_rel_early");
        chk(5, 4'b1111, 0, 4'b1110, 0, "rst_rel_on"); tick(5);

        // drain scoreboard with a bound
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick(1);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
